reg_file_mp: RTL and testbench

Parametrised multi-port register file. It supersedes the fixed 16x16, 2-read/1-write register file in the 16-bit RISC datapath.
- Adds a second write port with a defined collision priority.
- Register 0 is optionally hardwired to zero.
- A sequential clear engine zeroes every row after reset or on a soft-clear request, so no read ever returns X.
- Sits between decode (read addresses) and writeback (write ports).

---
 rtl/reg_file_mp.sv | 118 +++++++++++
 tb/tb_reg_file_mp.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised 2-read / 2-write register file with a sequential
// clear engine that zeroes every row after reset or on a soft-clear request.
// Optional feature macro: REG_FILE_BYPASS_EN (write-to-read forwarding in IDLE).
module reg_file_mp #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter bit          ZERO_R0 = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  input  logic [ADDR_W-1:0] WA0,
  input  logic [DATA_W-1:0] WD0,
  input  logic              WE0,
  input  logic [ADDR_W-1:0] WA1,
  input  logic [DATA_W-1:0] WD1,
  input  logic              WE1,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2,
  output logic              busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              clr_we_c;
  logic              wr0_c, wr1_c;
  logic [DATA_W-1:0] rows [DEPTH];

  // State and sweep-pointer register; reset restarts the sweep at row 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Next-state logic: soft clear from IDLE, one row per edge while clearing.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    clr_we_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end
      end
      CLEAR: begin
        clr_we_c  = 1'b1;
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q == CLEAR);

  // Write qualification: IDLE only, row 0 protected when hardwired to zero.
  always_comb begin
    wr0_c = WE0 && (state_q == IDLE) && !(ZERO_R0 && (WA0 == '0));
    wr1_c = WE1 && (state_q == IDLE) && !(ZERO_R0 && (WA1 == '0));
  end

  // Row storage: clear sweep or functional writes; port 1 wins a collision.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clr_we_c) begin
        rows[clr_ptr_q] <= '0;
      end else begin
        if (wr0_c) rows[WA0] <= WD0;
        if (wr1_c) rows[WA1] <= WD1;
      end
    end
  end

  // Read port 1: stored value, optional forwarding, then zero/busy forcing.
  always_comb begin
    data_out1 = rows[RA1];
`ifdef REG_FILE_BYPASS_EN
    if (state_q == IDLE) begin
      if (WE0 && (WA0 == RA1)) data_out1 = WD0;
      if (WE1 && (WA1 == RA1)) data_out1 = WD1;
    end
`endif
    if (busy || (ZERO_R0 && (RA1 == '0))) data_out1 = '0;
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    data_out2 = rows[RA2];
`ifdef REG_FILE_BYPASS_EN
    if (state_q == IDLE) begin
      if (WE0 && (WA0 == RA2)) data_out2 = WD0;
      if (WE1 && (WA1 == RA2)) data_out2 = WD1;
    end
`endif
    if (busy || (ZERO_R0 && (RA2 == '0))) data_out2 = '0;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed steps, read scoreboard queue.
module tb_reg_file_mp;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 16;

  logic              clk = 1'b0;
  logic              reset, clr_req;
  logic [ADDR_W-1:0] RA1, RA2, WA0, WA1;
  logic [DATA_W-1:0] WD0, WD1;
  logic              WE0, WE1;
  logic [DATA_W-1:0] data_out1, data_out2;
  logic              busy;

  always #5 clk = ~clk;

  reg_file_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_R0(1'b1)) dut (
    .clk(clk), .reset(reset), .clr_req(clr_req),
    .RA1(RA1), .RA2(RA2),
    .WA0(WA0), .WD0(WD0), .WE0(WE0),
    .WA1(WA1), .WD1(WD1), .WE1(WE1),
    .data_out1(data_out1), .data_out2(data_out2), .busy(busy)
  );

  typedef struct {
    string             tag;
    logic [DATA_W-1:0] exp;
  } sb_t;

  sb_t               sb_q[$];
  logic [DATA_W-1:0] model [DEPTH];
  int                tests  = 0;
  int                failed = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_busy(input string tag, input logic exp);
    check(tag, DATA_W'(busy), DATA_W'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
  endtask

  function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a,
                                                   input logic bsy);
    if (bsy || a == '0) return '0;
    return model[a];
  endfunction

  // Drive one write cycle on both ports and mirror it in the model.
  task automatic do_write(input logic we0, input logic [ADDR_W-1:0] wa0,
                          input logic [DATA_W-1:0] wd0, input logic we1,
                          input logic [ADDR_W-1:0] wa1, input logic [DATA_W-1:0] wd1);
    WE0 = we0; WA0 = wa0; WD0 = wd0;
    WE1 = we1; WA1 = wa1; WD1 = wd1;
    tick();
    if (we0 && wa0 != '0) model[wa0] = wd0;
    if (we1 && wa1 != '0) model[wa1] = wd1;
    WE0 = 1'b0; WE1 = 1'b0;
  endtask

  // Push expected read data, then pop and compare against both ports.
  task automatic read_pair(input string tag, input logic [ADDR_W-1:0] a1,
                           input logic [ADDR_W-1:0] a2, input logic bsy);
    sb_t e;
    RA1 = a1; RA2 = a2;
    sb_q.push_back('{tag: {tag, ".rd1"}, exp: model_read(a1, bsy)});
    sb_q.push_back('{tag: {tag, ".rd2"}, exp: model_read(a2, bsy)});
    #1;
    e = sb_q.pop_front(); check(e.tag, data_out1, e.exp);
    e = sb_q.pop_front(); check(e.tag, data_out2, e.exp);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; clr_req = 1'b0;
    RA1 = '0; RA2 = '0; WA0 = '0; WA1 = '0; WD0 = '0; WD1 = '0;
    WE0 = 1'b0; WE1 = 1'b0;

    // Reset held two cycles, then a full 16-edge sweep.
    tick(); check_busy("rst_busy_a", 1'b1);
    tick(); check_busy("rst_busy_b", 1'b1);
    reset = 1'b0;
    for (int i = 1; i <= int'(DEPTH); i++) begin
      tick();
      check_busy($sformatf("sweep_busy_%0d", i), (i < int'(DEPTH)));
    end
    model_clear();
    read_pair("post_sweep", 4'd8, 4'd15, 1'b0);

    // Reset again five edges into a sweep: the sweep restarts.
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 1; i <= 5; i++) tick();
    check_busy("mid_busy", 1'b1);
    reset = 1'b1; tick(); check_busy("rerst_busy", 1'b1);
    reset = 1'b0;
    for (int i = 1; i <= int'(DEPTH); i++) begin
      tick();
      check_busy($sformatf("resweep_busy_%0d", i), (i < int'(DEPTH)));
    end

    // Single write, then a disabled write that must not change the row.
    do_write(1'b1, 4'd8, 16'h8A37, 1'b0, 4'd0, 16'h0000);
    read_pair("wr_single", 4'd8, 4'd1, 1'b0);
    do_write(1'b0, 4'd8, 16'h0104, 1'b0, 4'd0, 16'h0000);
    read_pair("wr_disabled", 4'd8, 4'd8, 1'b0);

    // Collision on row 15 (port 1 wins), then distinct rows 3 and 4.
    do_write(1'b1, 4'd15, 16'h1111, 1'b1, 4'd15, 16'h2222);
    read_pair("collide", 4'd8, 4'd15, 1'b0);
    do_write(1'b1, 4'd3, 16'hAAAA, 1'b1, 4'd4, 16'h5555);
    read_pair("dual", 4'd3, 4'd4, 1'b0);

    // Row 0 hardwired to zero.
    do_write(1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0, 16'hFFFF);
    read_pair("row0", 4'd0, 4'd3, 1'b0);

    // Soft clear: reads forced to 0, writes ignored, rows zero afterwards.
    do_write(1'b1, 4'd8, 16'h80D2, 1'b1, 4'd15, 16'h80D2);
    read_pair("pre_clr", 4'd8, 4'd15, 1'b0);
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    check_busy("clr_busy", 1'b1);
    read_pair("clr_rd0", 4'd8, 4'd15, 1'b1);
    for (int i = 1; i <= int'(DEPTH); i++) begin
      if (i == 5) begin WE0 = 1'b1; WA0 = 4'd8; WD0 = 16'h1234; end
      tick();
      WE0 = 1'b0;
      check_busy($sformatf("clr_busy_%0d", i), (i < int'(DEPTH)));
      if (i == 8) read_pair("clr_rd_mid", 4'd8, 4'd15, 1'b1);
    end
    model_clear();
    read_pair("post_clr", 4'd8, 4'd15, 1'b0);

    // Same-cycle write and read of row 5.
    WE1 = 1'b1; WA1 = 4'd5; WD1 = 16'hBEEF; RA1 = 4'd5;
    #1;
`ifdef REG_FILE_BYPASS_EN
    check("bypass_pre", data_out1, 16'hBEEF);
`else
    check("bypass_pre", data_out1, model[5]);
`endif
    tick();
    model[5] = 16'hBEEF;
    WE1 = 1'b0;
    read_pair("bypass_post", 4'd5, 4'd8, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
